lb_tx_rr_merge: RTL and testbench

// - TX-side counterpart of the RR load balancer. Merges per-core egress DATA streams (tuser = {core_id,tag})

---
 rtl/lb_tx_rr_merge_pkg.sv | 24 ++
 rtl/lb_tx_rr_merge_if.sv | 17 +
 rtl/lb_tx_rr_merge_arb.sv | 24 ++
 rtl/lb_tx_rr_merge.sv | 222 ++++++++++++++++++++++
 tb/tb_lb_tx_rr_merge.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_tx_rr_merge_pkg.sv
// Shared definitions for the TX round-robin merge: release message layout,
// FSM state encoding and a saturating byte-count helper.
package lb_tx_rr_merge_pkg;

   localparam logic [3:0] REL_MSG_TYPE  = 4'h1;
   localparam int         REL_LEN_LSB   = 16;
   localparam int         REL_TYPE_LSB  = 32;
   localparam int         REL_LEN_WIDTH = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [REL_LEN_WIDTH-1:0] sat_add16(
      input logic [REL_LEN_WIDTH-1:0] a,
      input logic [REL_LEN_WIDTH-1:0] b
   );
      logic [REL_LEN_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[REL_LEN_WIDTH] ? {REL_LEN_WIDTH{1'b1}} : s[REL_LEN_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/lb_tx_rr_merge_if.sv
// AXI-Stream bundle carrying N lanes packed side by side; N=1 for a plain stream.
interface lb_tx_rr_merge_if #(
   parameter int N  = 1,
   parameter int DW = 8,
   parameter int KW = 1,
   parameter int UW = 1
) ();
   logic [N*DW-1:0] tdata;
   logic [N*KW-1:0] tkeep;
   logic [N*UW-1:0] tuser;
   logic [N-1:0]    tvalid;
   logic [N-1:0]    tlast;
   logic [N-1:0]    tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/lb_tx_rr_merge_arb.sv
// Rotating-priority arbiter: one-hot grant to the first requester strictly
// after last_i, wrapping around.
module lb_tx_rr_arb #(
   parameter int N  = 3,
   parameter int GW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [GW-1:0] last_i,
   output logic [N-1:0]  grant_o
);
   always_comb begin
      int c;
      c       = 0;
      grant_o = '0;
      // Walk from the farthest offset down so the nearest requester wins.
      for (int off = N; off >= 1; off--) begin
         c = (int'(last_i) + off) % N;
         if (req_i[c]) begin
            grant_o    = '0;
            grant_o[c] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/lb_tx_rr_merge.sv
// Packet-atomic round-robin merge of per-core egress streams onto one TX stream,
// with a slot-release message per forwarded packet. Optional stats: LB_TX_STATS_EN.
module lb_tx_rr_merge
   import lb_tx_rr_merge_pkg::*;
#(
   parameter int S_COUNT       = 3,
   parameter int DATA_WIDTH    = 512,
   parameter int STRB_WIDTH    = DATA_WIDTH/8,
   parameter int CORE_ID_WIDTH = 3,
   parameter int TAG_WIDTH     = 6,
   parameter int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH,
   parameter int CTRL_WIDTH    = 36,
   parameter int REL_DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   lb_tx_rr_merge_if.slave       s_axis,
   lb_tx_rr_merge_if.master      m_axis,
   lb_tx_rr_merge_if.master      rel_m_axis,
   input  logic [28:0]           host_cmd,
   input  logic [31:0]           host_cmd_wr_data,
   input  logic                  host_cmd_wr_en,
   output logic [31:0]           host_cmd_rd_data
);
   localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
   localparam int AW = $clog2(REL_DEPTH);
   localparam logic [AW:0] REL_FULL = REL_DEPTH[AW:0];

   logic [DATA_WIDTH-1:0]   s_data [S_COUNT];
   logic [STRB_WIDTH-1:0]   s_keep [S_COUNT];
   logic [ID_TAG_WIDTH-1:0] s_user [S_COUNT];

   genvar gi;
   generate
      for (gi = 0; gi < S_COUNT; gi++) begin : g_unpack
         assign s_data[gi] = s_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign s_keep[gi] = s_axis.tkeep[gi*STRB_WIDTH +: STRB_WIDTH];
         assign s_user[gi] = s_axis.tuser[gi*ID_TAG_WIDTH +: ID_TAG_WIDTH];
      end
   endgenerate

   state_t                  state_q, state_d;
   logic [GW-1:0]           grant_q, grant_d, last_q, last_d;
   logic [ID_TAG_WIDTH-1:0] tuser_q, tuser_d;
   logic [15:0]             byte_q, byte_d;

   logic [S_COUNT-1:0]      arb_onehot;
   logic [GW-1:0]           arb_idx;
   logic                    arb_any;

   lb_tx_rr_arb #(.N(S_COUNT), .GW(GW)) u_arb (
      .req_i   (s_axis.tvalid),
      .last_i  (last_q),
      .grant_o (arb_onehot)
   );

   always_comb begin
      arb_idx = '0;
      for (int k = 0; k < S_COUNT; k++) begin
         if (arb_onehot[k]) arb_idx = arb_idx | GW'(k);
      end
      arb_any = |arb_onehot;
   end

   logic                  busy, sel_valid, sel_last, beat_acc, last_acc;
   logic [STRB_WIDTH-1:0] sel_keep;
   logic [15:0]           beat_bytes, byte_sum;
   logic [CTRL_WIDTH-1:0] rel_msg;
   logic [S_COUNT-1:0]    s_ready;

   assign busy      = (state_q == ST_BUSY);
   assign sel_valid = s_axis.tvalid[grant_q];
   assign sel_last  = s_axis.tlast[grant_q];
   assign sel_keep  = s_keep[grant_q];
   assign beat_acc  = busy & sel_valid & m_axis.tready;
   assign last_acc  = beat_acc & sel_last;

   always_comb begin
      beat_bytes = '0;
      for (int k = 0; k < STRB_WIDTH; k++) begin
         beat_bytes = beat_bytes + 16'(sel_keep[k]);
      end
   end

   assign byte_sum = sat_add16(byte_q, beat_bytes);

   // Length field includes the tlast beat, so it is built from the running sum.
   always_comb begin
      rel_msg                              = '0;
      rel_msg[REL_TYPE_LSB +: 4]           = REL_MSG_TYPE;
      rel_msg[REL_LEN_LSB +: REL_LEN_WIDTH] = byte_sum;
      rel_msg[ID_TAG_WIDTH-1:0]            = tuser_q;
   end

   logic [CTRL_WIDTH-1:0] rel_mem_q [REL_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           cnt_q;
   logic                  rel_valid, rel_pop;

   assign rel_valid = (cnt_q != '0);
   assign rel_pop   = rel_valid & rel_m_axis.tready;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      tuser_d = tuser_q;
      byte_d  = byte_q;
      s_ready = '0;
      case (state_q)
         ST_IDLE: begin
            // A free release slot is reserved up front so the tlast push can never stall.
            if (arb_any && (cnt_q < REL_FULL)) begin
               grant_d = arb_idx;
               tuser_d = s_user[arb_idx];
               byte_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            s_ready[grant_q] = m_axis.tready;
            if (beat_acc) byte_d = byte_sum;
            if (last_acc) begin
               last_d  = grant_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= '0;
         tuser_q <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         tuser_q <= tuser_d;
         byte_q  <= byte_d;
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = busy & sel_valid;
   assign m_axis.tlast  = busy & sel_last;
   assign m_axis.tdata  = busy ? s_data[grant_q] : '0;
   assign m_axis.tkeep  = busy ? sel_keep : '0;
   assign m_axis.tuser  = busy ? tuser_q : '0;

   always_ff @(posedge clk) begin
      if (last_acc) rel_mem_q[wr_ptr_q] <= rel_msg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (last_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rel_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(last_acc) - (AW+1)'(rel_pop);
      end
   end

   assign rel_m_axis.tvalid = rel_valid;
   assign rel_m_axis.tdata  = rel_valid ? rel_mem_q[rd_ptr_q] : '0;
   assign rel_m_axis.tlast  = rel_valid;
   assign rel_m_axis.tkeep  = '1;
   assign rel_m_axis.tuser  = '0;

`ifdef LB_TX_STATS_EN
   logic [31:0] pkt_cnt_q  [S_COUNT];
   logic [31:0] byte_tot_q [S_COUNT];
   logic [31:0] rd_d, rd_q;
   logic [7:0]  cmd_idx;
   logic        unused_host;

   assign cmd_idx     = host_cmd[8:1];
   assign unused_host = ^{host_cmd[28:9], host_cmd_wr_data};

   generate
      for (gi = 0; gi < S_COUNT; gi++) begin : g_stats
         logic clr, hit;
         assign clr = host_cmd_wr_en && (cmd_idx == 8'(gi));
         assign hit = beat_acc && (grant_q == GW'(gi));
         // Clear has priority over a same-cycle increment.
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               pkt_cnt_q[gi]  <= '0;
               byte_tot_q[gi] <= '0;
            end else if (hit) begin
               byte_tot_q[gi] <= byte_tot_q[gi] + 32'(beat_bytes);
               if (sel_last) pkt_cnt_q[gi] <= pkt_cnt_q[gi] + 32'd1;
            end
         end
      end
   endgenerate

   always_comb begin
      rd_d = '0;
      if (cmd_idx < 8'(S_COUNT)) rd_d = host_cmd[0] ? byte_tot_q[cmd_idx] : pkt_cnt_q[cmd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
   end

   assign host_cmd_rd_data = rd_q;
`else
   logic unused_host;
   assign unused_host      = ^{host_cmd, host_cmd_wr_data, host_cmd_wr_en};
   assign host_cmd_rd_data = '0;
`endif

endmodule

// File: tb/tb_lb_tx_rr_merge.sv
// Scoreboard bench for lb_tx_rr_merge: per-input stimulus/expectation queues,
// release messages matched in packet order, stats checked when LB_TX_STATS_EN is set.
module tb_lb_tx_rr_merge;
   localparam int S  = 3;
   localparam int DW = 512;
   localparam int KW = DW/8;
   localparam int UW = 9;
   localparam int CW = 36;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lb_tx_rr_merge_if #(.N(S), .DW(DW), .KW(KW), .UW(UW)) s_if ();
   lb_tx_rr_merge_if #(.N(1), .DW(DW), .KW(KW), .UW(UW)) m_if ();
   lb_tx_rr_merge_if #(.N(1), .DW(CW), .KW(1),  .UW(1))  r_if ();

   logic [28:0] host_cmd = '0;
   logic [31:0] host_cmd_wr_data = '0;
   logic        host_cmd_wr_en = 1'b0;
   logic [31:0] host_cmd_rd_data;

   lb_tx_rr_merge #(
      .S_COUNT(S), .DATA_WIDTH(DW), .CORE_ID_WIDTH(3), .TAG_WIDTH(6),
      .CTRL_WIDTH(CW), .REL_DEPTH(4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis           (s_if),
      .m_axis           (m_if),
      .rel_m_axis       (r_if),
      .host_cmd         (host_cmd),
      .host_cmd_wr_data (host_cmd_wr_data),
      .host_cmd_wr_en   (host_cmd_wr_en),
      .host_cmd_rd_data (host_cmd_rd_data)
   );

   int checks = 0;
   int errors = 0;

   beat_t         stim_q    [S][$];
   beat_t         exp_q     [S][$];
   logic [CW-1:0] rel_src_q [S][$];
   logic [CW-1:0] rel_q     [$];
   int            exp_order [$];

   int            mready_mode = 0;
   logic          tog = 1'b0;
   logic          rel_rdy = 1'b1;
   logic          in_pkt = 1'b0;
   int            cur_src = 0;
   logic          bubble_pend = 1'b0;
   int            pkts_fwd = 0;
   int            beats_fwd = 0;
   int            seq = 0;
   logic [CW-1:0] last_rel = '0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int next_src(input int last, input logic [S-1:0] mask);
      for (int off = 1; off <= S; off++) begin
         if (mask[(last + off) % S]) return (last + off) % S;
      end
      return -1;
   endfunction

   function automatic int pending();
      int n;
      n = rel_q.size();
      for (int i = 0; i < S; i++) n += stim_q[i].size() + exp_q[i].size() + rel_src_q[i].size();
      return n;
   endfunction

   task automatic add_pkt(input int src, input logic [UW-1:0] user, input int nbeats,
                          input logic [KW-1:0] keep_last);
      beat_t b;
      int    bytes;
      bytes = 0;
      for (int k = 0; k < nbeats; k++) begin
         for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
         b.data[7:0]   = 8'(src);
         b.data[15:8]  = 8'(seq);
         b.data[23:16] = 8'(k);
         b.keep = (k == nbeats-1) ? keep_last : {KW{1'b1}};
         b.last = (k == nbeats-1);
         b.user = (k == 0) ? user : ~user;
         bytes += $countones(b.keep);
         stim_q[src].push_back(b);
         exp_q[src].push_back(b);
      end
      rel_src_q[src].push_back({4'h1, 16'(bytes), 7'd0, user});
      seq++;
   endtask

   task automatic monitor_beat();
      int    src;
      beat_t e;
      src = int'(m_if.tdata[7:0]);
      if (!in_pkt) begin
         in_pkt  = 1'b1;
         cur_src = src;
         if (exp_order.size() > 0) chk("grant_order", 32'(src), 32'(exp_order.pop_front()));
         if (src < S && rel_src_q[src].size() > 0) rel_q.push_back(rel_src_q[src].pop_front());
      end else begin
         chk("no_interleave", 32'(src), 32'(cur_src));
      end
      chk("beat_expected", DW'((src < S) && (exp_q[src].size() > 0)), 1);
      if (src < S && exp_q[src].size() > 0) begin
         e = exp_q[src].pop_front();
         chk("m_data", m_if.tdata, e.data);
         chk("m_keep", m_if.tkeep, e.keep);
         chk("m_last", m_if.tlast, e.last);
      end
      beats_fwd++;
      if (m_if.tlast) begin
         in_pkt      = 1'b0;
         bubble_pend = 1'b1;
         pkts_fwd++;
         $display("pkt  src=%0d seq=%0d total_pkts=%0d", src, m_if.tdata[15:8], pkts_fwd);
      end
   endtask

   task automatic step();
      beat_t b;
      @(negedge clk);
      for (int i = 0; i < S; i++) begin
         if (stim_q[i].size() > 0) begin
            b = stim_q[i][0];
            s_if.tvalid[i]            = 1'b1;
            s_if.tdata[i*DW +: DW]    = b.data;
            s_if.tkeep[i*KW +: KW]    = b.keep;
            s_if.tlast[i]             = b.last;
            s_if.tuser[i*UW +: UW]    = b.user;
         end else begin
            s_if.tvalid[i] = 1'b0;
            s_if.tlast[i]  = 1'b0;
         end
      end
      tog         = ~tog;
      m_if.tready = (mready_mode == 0) ? 1'b1 : tog;
      r_if.tready = rel_rdy;
      #1;
      if (bubble_pend) begin
         chk("idle_bubble", m_if.tvalid, 0);
         bubble_pend = 1'b0;
      end
      for (int i = 0; i < S; i++) begin
         if (s_if.tvalid[i] && s_if.tready[i]) void'(stim_q[i].pop_front());
      end
      if (m_if.tvalid && m_if.tready) monitor_beat();
      if (r_if.tvalid && r_if.tready) begin
         chk("rel_expected", DW'(rel_q.size() > 0), 1);
         if (rel_q.size() > 0) chk("rel_msg", r_if.tdata, rel_q.pop_front());
         last_rel = r_if.tdata;
         $display("rel  msg=%h", r_if.tdata);
      end
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (pending() > 0 && n < max) begin
         step();
         n++;
      end
      repeat (2) step();
      chk("drain", 32'(pending()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n;
      int ml;
      int cnt [S];
      logic [S-1:0] mask;

      s_if.tvalid = '0;
      s_if.tlast  = '0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tuser  = '0;
      m_if.tready = 1'b0;
      r_if.tready = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_rel_tvalid", r_if.tvalid, 0);
      chk("rst_rd_data", host_cmd_rd_data, 0);
      rst = 1'b0;

      // single 3-beat packet on input 0
      p0 = beats_fwd;
      add_pkt(0, 9'h0A5, 3, KW'(16'h00FF));
      exp_order.push_back(0);
      drain(50);
      chk("t1_beats", 32'(beats_fwd - p0), 3);
      chk("t1_rel", last_rel, 36'h1_0088_00A5);

      // all inputs, two packets each; expected order from the rotating pointer
      p0 = pkts_fwd;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < S; i++) begin
            add_pkt(i, {3'(i), 6'(k + 8)}, 1 + ((i + k) % 3), KW'({$urandom, $urandom}));
         end
      end
      ml = 0;
      for (int i = 0; i < S; i++) cnt[i] = 2;
      repeat (2*S) begin
         for (int i = 0; i < S; i++) mask[i] = (cnt[i] > 0);
         n = next_src(ml, mask);
         exp_order.push_back(n);
         cnt[n]--;
         ml = n;
      end
      drain(200);
      chk("t2_pkts", 32'(pkts_fwd - p0), 6);

      // release back-pressure: four slots, fifth packet held
      rel_rdy = 1'b0;
      p0 = pkts_fwd;
      for (int k = 0; k < 5; k++) add_pkt(1, {3'd1, 6'(k)}, 1, {KW{1'b1}});
      repeat (30) step();
      chk("t3_fwd_four", 32'(pkts_fwd - p0), 4);
      chk("t3_held_ready", s_if.tready[1], 0);
      chk("t3_held_valid", s_if.tvalid[1], 1);
      rel_rdy = 1'b1;
      step();
      rel_rdy = 1'b0;
      repeat (10) step();
      chk("t3_fwd_five", 32'(pkts_fwd - p0), 5);
      rel_rdy = 1'b1;
      drain(100);

      // m_tready toggling; last-beat keep of one byte and of zero bytes
      mready_mode = 1;
      add_pkt(2, 9'h1C3, 4, KW'(1));
      add_pkt(2, 9'h0F0, 2, '0);
      drain(100);
      mready_mode = 0;
      chk("t4_zero_keep_rel", last_rel, 36'h1_0040_00F0);

      // reset on beat 2 of 4 with a release still queued
      rel_rdy = 1'b0;
      add_pkt(0, 9'h011, 1, {KW{1'b1}});
      add_pkt(0, 9'h012, 4, {KW{1'b1}});
      n = 0;
      while (stim_q[0].size() > 3 && n < 50) begin
         step();
         n++;
      end
      chk("t5_reach_beat2", 32'(stim_q[0].size()), 3);
      @(negedge clk);
      rst         = 1'b1;
      m_if.tready = 1'b0;
      @(negedge clk);
      #1;
      chk("t5_m_tvalid", m_if.tvalid, 0);
      chk("t5_s_tready", s_if.tready, 0);
      chk("t5_rel_flushed", r_if.tvalid, 0);
      for (int i = 0; i < S; i++) begin
         stim_q[i].delete();
         exp_q[i].delete();
         rel_src_q[i].delete();
      end
      rel_q.delete();
      exp_order.delete();
      in_pkt      = 1'b0;
      bubble_pend = 1'b0;
      s_if.tvalid = '0;
      rst         = 1'b0;
      rel_rdy     = 1'b1;
      add_pkt(0, 9'h021, 2, {KW{1'b1}});
      add_pkt(2, 9'h0A2, 1, KW'(16'h0F0F));
      exp_order.push_back(2);
      exp_order.push_back(0);
      drain(50);

`ifdef LB_TX_STATS_EN
      for (int k = 0; k < 10; k++) add_pkt(1, {3'd1, 6'(k)}, 1, {KW{1'b1}});
      drain(100);
      host_cmd = 29'h2;
      repeat (2) step();
      chk("st_pkts", host_cmd_rd_data, 10);
      host_cmd = 29'h3;
      repeat (2) step();
      chk("st_bytes", host_cmd_rd_data, 640);
      host_cmd = 29'hA;
      repeat (2) step();
      chk("st_out_of_range", host_cmd_rd_data, 0);
      host_cmd       = 29'h2;
      host_cmd_wr_en = 1'b1;
      step();
      host_cmd_wr_en = 1'b0;
      repeat (2) step();
      chk("st_pkts_cleared", host_cmd_rd_data, 0);
      host_cmd = 29'h3;
      repeat (2) step();
      chk("st_bytes_cleared", host_cmd_rd_data, 0);
`else
      host_cmd       = 29'h3;
      host_cmd_wr_en = 1'b1;
      repeat (2) step();
      host_cmd_wr_en = 1'b0;
      chk("nostats_rd_zero", host_cmd_rd_data, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
